mem_wb_stage: RTL and testbench

- Memory-access and write-back end of the 5-stage MIPS pipeline; the producer of the register-file write port (WriteReg/WriteData/Writebit) that the decode stage consumes.
- Accepts the EX/MEM bundle, performs word load/store on an internal data memory, holds the MEM/WB pipeline register, and drives the write-back triple.
- Also tracks retired instructions and reports misaligned accesses.

---
 rtl/mips_pkg.sv | 17 +
 rtl/data_memory.sv | 21 ++
 rtl/mem_wb_stage.sv | 77 +++++++
 tb/tb_mem_wb_stage.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline back end: register-zero index,
// word size and the MEM/WB pipeline-register bundle.
package mips_pkg;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam int         WORD_BYTES = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wreg;
    logic        RegWrite;
    logic        MemToReg;
    logic [31:0] alu;
    logic [31:0] load;
  } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Single-port word-addressed data memory: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module data_memory #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM and WB end of the 5-stage MIPS pipeline: word load/store, MEM/WB register,
// register-file write port, retired-instruction counter and sticky alignment flag.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      store_data,
  input  logic [4:0]       write_reg_in,
  input  logic             RegWrite,
  input  logic             MemToReg,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic             stall,
  input  logic             flush,
  output logic [4:0]       WriteReg,
  output logic [31:0]      WriteData,
  output logic             Writebit,
  output logic             align_err,
  output logic [CNT_W-1:0] retired
);

  mem_wb_t            mwb_q, mwb_d;
  logic [ADDR_W-1:0]  index;
  logic [31:0]        rdata;
  logic               misaligned;
  logic               mem_we;
  logic               unused_addr;

  // Upper address bits are dropped so accesses wrap modulo the memory depth.
  assign index       = alu_result[ADDR_W+1:2];
  assign unused_addr = ^alu_result[31:ADDR_W+2];
  assign misaligned  = valid_in & (MemRead | MemWrite) & (alu_result[1:0] != 2'b00);
  // rst gating aborts a store whose edge lands while reset is held.
  assign mem_we      = valid_in & MemWrite & ~misaligned & ~stall & ~flush & ~rst;

  data_memory #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (index),
    .wdata (store_data),
    .rdata (rdata)
  );

  always_comb begin
    mwb_d          = mwb_q;
    mwb_d.valid    = valid_in & ~misaligned;
    mwb_d.wreg     = write_reg_in;
    mwb_d.RegWrite = RegWrite;
    mwb_d.MemToReg = MemToReg;
    mwb_d.alu      = alu_result;
    mwb_d.load     = rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mwb_q     <= '0;
      align_err <= 1'b0;
      retired   <= '0;
    end else begin
      if (flush)       mwb_q.valid <= 1'b0;
      else if (!stall) mwb_q       <= mwb_d;
      if (misaligned && !stall && !flush) align_err <= 1'b1;
      if (mwb_q.valid && !stall)          retired   <= retired + CNT_W'(1);
    end
  end

  assign WriteData = mwb_q.MemToReg ? mwb_q.load : mwb_q.alu;
  assign WriteReg  = mwb_q.wreg;
  assign Writebit  = mwb_q.valid & mwb_q.RegWrite & (mwb_q.wreg != REG_ZERO);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: hand-computed vectors checked by immediate assertions.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [4:0]  write_reg_in;
  logic        RegWrite, MemToReg, MemRead, MemWrite;
  logic        stall, flush;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        Writebit;
  logic        align_err;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mem_wb_stage #(.ADDR_W(8), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .alu_result   (alu_result),
    .store_data   (store_data),
    .write_reg_in (write_reg_in),
    .RegWrite     (RegWrite),
    .MemToReg     (MemToReg),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .stall        (stall),
    .flush        (flush),
    .WriteReg     (WriteReg),
    .WriteData    (WriteData),
    .Writebit     (Writebit),
    .align_err    (align_err),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; alu_result = 0; store_data = 0; write_reg_in = 0;
    RegWrite = 0; MemToReg = 0; MemRead = 0; MemWrite = 0;
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [4:0] r);
    idle(); valid_in = 1; alu_result = a; write_reg_in = r; RegWrite = 1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    idle(); valid_in = 1; alu_result = a; store_data = d; MemWrite = 1;
  endtask

  task automatic load(input logic [31:0] a, input logic [4:0] r);
    idle(); valid_in = 1; alu_result = a; write_reg_in = r;
    RegWrite = 1; MemToReg = 1; MemRead = 1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    idle();
    #3;
    chk("rst_wreg",  32'(WriteReg), 0);
    chk("rst_wdata", WriteData, 0);
    chk("rst_wbit",  32'(Writebit), 0);
    chk("rst_aerr",  32'(align_err), 0);
    chk("rst_ret",   retired, 0);
    @(negedge clk); rst = 0;

    // ALU op into r8
    alu_op(32'h1234, 5'd8); tick();
    chk("alu_wreg",  32'(WriteReg), 8);
    chk("alu_wdata", WriteData, 32'h1234);
    chk("alu_wbit",  32'(Writebit), 1);

    // store then load of same word
    store(32'h40, 32'hDEADBEEF); tick();
    chk("st_ret",  retired, 1);
    chk("st_wbit", 32'(Writebit), 0);
    load(32'h40, 5'd9); tick();
    chk("ld_wdata", WriteData, 32'hDEADBEEF);
    chk("ld_wreg",  32'(WriteReg), 9);
    chk("ld_wbit",  32'(Writebit), 1);
    chk("ld_ret",   retired, 2);

    // write to r0 is suppressed but still retires
    alu_op(32'd5, 5'd0); tick();
    chk("r0_wbit",  32'(Writebit), 0);
    chk("r0_wdata", WriteData, 5);
    chk("r0_ret",   retired, 3);
    idle(); tick();
    chk("r0_ret2",  retired, 4);
    chk("aerr_0",   32'(align_err), 0);

    // misaligned load, then sticky flag
    load(32'h42, 5'd10); tick();
    chk("mis_ld_wbit", 32'(Writebit), 0);
    chk("mis_ld_aerr", 32'(align_err), 1);
    idle(); tick();
    chk("aerr_sticky", 32'(align_err), 1);
    chk("mis_ret",     retired, 4);

    // misaligned store must not touch mem[0x10]
    store(32'h41, 32'h12345678); tick();
    load(32'h40, 5'd11); tick();
    chk("mis_st_rb", WriteData, 32'hDEADBEEF);
    chk("mis_st_wb", 32'(Writebit), 1);

    // stall for 3 cycles during a valid store: outputs frozen
    store(32'h40, 32'hCAFEF00D); stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_wbit",  32'(Writebit), 1);
      chk("stl_wreg",  32'(WriteReg), 11);
      chk("stl_wdata", WriteData, 32'hDEADBEEF);
      chk("stl_ret",   retired, 4);
    end
    stall = 0;
    load(32'h40, 5'd12); tick();
    chk("stl_rb",   WriteData, 32'hDEADBEEF);
    chk("stl_rreg", 32'(WriteReg), 12);
    chk("stl_ret2", retired, 5);

    // flush wins over stall
    alu_op(32'h77, 5'd13); stall = 1; flush = 1; tick();
    chk("fs_wbit", 32'(Writebit), 0);
    chk("fs_ret",  retired, 5);
    stall = 0; flush = 0;
    idle(); tick();
    chk("fs_ret2", retired, 5);

    // flushed store is suppressed
    store(32'h40, 32'h55); flush = 1; tick();
    flush = 0;
    load(32'h40, 5'd15); tick();
    chk("fl_st_rb", WriteData, 32'hDEADBEEF);
    chk("fl_ret",   retired, 5);

    // address wrap: 0x400 aliases word 0
    store(32'h400, 32'h11); tick();
    chk("wrap_ret", retired, 6);
    load(32'h0, 5'd14); tick();
    chk("wrap_wdata", WriteData, 32'h11);
    chk("wrap_wreg",  32'(WriteReg), 14);
    chk("wrap_wbit",  32'(Writebit), 1);
    chk("wrap_ret2",  retired, 7);

    // asynchronous reset mid-run
    idle(); #2; rst = 1; #1;
    chk("arst_wbit",  32'(Writebit), 0);
    chk("arst_wdata", WriteData, 0);
    chk("arst_aerr",  32'(align_err), 0);
    chk("arst_ret",   retired, 0);
    @(negedge clk); rst = 0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
